// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared constants for the register file and its scoreboard
package regfile_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/write-back bundle for the register file.
//   master (decode + write-back) drives ra1, ra2, we, wa, wd, iss_en, iss_dst.
//   slave (register file) drives rd1, rd2, busy1, busy2, iss_full.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic [REG_ADDR_W-1:0] ra1, ra2, wa, iss_dst;
  logic [DATA_W-1:0] rd1, rd2, wd;
  logic we, iss_en, busy1, busy2, iss_full;
  modport master(
    output ra1, ra2, we, wa, wd, iss_en, iss_dst,
    input  rd1, rd2, busy1, busy2, iss_full
  );
  modport slave(
    input  ra1, ra2, we, wa, wd, iss_en, iss_dst,
    output rd1, rd2, busy1, busy2, iss_full
  );
endinterface

// File: rtl/reg_file_sb_sb_counter.sv
// sb_counter: saturating up/down count of in-flight writes to one register.
//   clk, rst (async active-low); inc_i / dec_i request a step;
//   nz_o = count nonzero, full_o = count saturated, one_o = count equals 1.
//   Requests that would overflow or underflow are dropped; inc+dec cancel.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic nz_o,
  output logic full_o,
  output logic one_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic up, dn;
  assign nz_o = |cnt_q;
  assign full_o = &cnt_q;
  assign one_o = cnt_q == CNT_W'(1);
  always_comb begin
    up = inc_i && !full_o;
    dn = dec_i && nz_o;
    cnt_d = (up && !dn) ? cnt_q + 1'b1 : (dn && !up) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 32x32 MIPS register file with per-register outstanding-write scoreboard.
//   clk, rst (async active-low); bus: reg_file_sb_if.slave (reads, write-back, issue, hazard flags).
//   REGFILE_BYPASS_EN: forward same-cycle write-back data to the read ports and
//   drop busy when that write retires the last outstanding write.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W = 2
) (
  input logic clk,
  input logic rst,
  reg_file_sb_if.slave bus
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] nz, full, one;
  logic hit1, hit2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (bus.we && bus.wa != REG_ZERO) regs_q[bus.wa] <= bus.wd;
  assign nz[0] = 1'b0;
  assign full[0] = 1'b0;
  assign one[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc_i(bus.iss_en && bus.iss_dst == REG_ADDR_W'(r)),
      .dec_i(bus.we && bus.wa == REG_ADDR_W'(r)),
      .nz_o(nz[r]),
      .full_o(full[r]),
      .one_o(one[r])
    );
  end
  always_comb begin
    hit1 = BYP && bus.we && bus.wa == bus.ra1;
    hit2 = BYP && bus.we && bus.wa == bus.ra2;
    bus.rd1 = bus.ra1 == REG_ZERO ? '0 : hit1 ? bus.wd : regs_q[bus.ra1];
    bus.rd2 = bus.ra2 == REG_ZERO ? '0 : hit2 ? bus.wd : regs_q[bus.ra2];
    bus.busy1 = nz[bus.ra1] && !(hit1 && one[bus.ra1]);
    bus.busy2 = nz[bus.ra2] && !(hit2 && one[bus.ra2]);
    bus.iss_full = full[bus.iss_dst];
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed plus randomized checks of reg_file_sb against an array/count model
module tb_reg_file_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXC = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cmp = 0;
  int err = 0;
  logic [31:0] m_regs [32];
  int m_cnt [32];
  always #5 clk = ~clk;
  reg_file_sb_if #(.DATA_W(32)) bus();
  reg_file_sb #(.DATA_W(32), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i] = 0;
    end
  endtask
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (BYP && bus.we && bus.wa == a) return bus.wd;
    return m_regs[a];
  endfunction
  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    return !(BYP && m_cnt[a] == 1 && bus.we && bus.wa == a);
  endfunction
  task automatic check_all();
    chk("rd1", bus.rd1, m_rd(bus.ra1));
    chk("rd2", bus.rd2, m_rd(bus.ra2));
    chk("busy1", 32'(bus.busy1), 32'(m_busy(bus.ra1)));
    chk("busy2", 32'(bus.busy2), 32'(m_busy(bus.ra2)));
    chk("iss_full", 32'(bus.iss_full), 32'(bus.iss_dst != 0 && m_cnt[bus.iss_dst] == MAXC));
  endtask
  task automatic step();
    bit inc, dec;
    inc = bus.iss_en && bus.iss_dst != 0 && m_cnt[bus.iss_dst] < MAXC;
    dec = bus.we && bus.wa != 0 && m_cnt[bus.wa] > 0;
    if (bus.we && bus.wa != 0) m_regs[bus.wa] = bus.wd;
    if (inc) m_cnt[bus.iss_dst]++;
    if (dec) m_cnt[bus.wa]--;
  endtask
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    if (rst) step();
    @(negedge clk);
  endtask
  task automatic idle();
    bus.we = 1'b0;
    bus.iss_en = 1'b0;
  endtask
  task automatic rand_in();
    bus.ra1 = 5'($urandom_range(0, 7));
    bus.ra2 = 5'($urandom_range(0, 7));
    bus.wa = 5'($urandom_range(0, 7));
    bus.iss_dst = 5'($urandom_range(0, 7));
    bus.we = 1'($urandom);
    bus.iss_en = 1'($urandom);
    bus.wd = $urandom;
  endtask
  initial begin
    m_reset();
    bus.ra1 = 0; bus.ra2 = 0; bus.wa = 0; bus.iss_dst = 0; bus.wd = 0;
    idle();
    #3;
    chk("reset_rd1", bus.rd1, 32'h0);
    chk("reset_busy1", 32'(bus.busy1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.ra1 = 5; bus.we = 1'b1; bus.wa = 5; bus.wd = 32'hDEADBEEF;
    tick();
    idle();
    #1 chk("wr_rd1", bus.rd1, 32'hDEADBEEF);
    tick();
    bus.we = 1'b1; bus.wa = 0; bus.wd = 32'h0000BABE; bus.ra2 = 0;
    tick();
    idle();
    #1 chk("zero_rd2", bus.rd2, 32'h0);
    tick();
    bus.iss_en = 1'b1; bus.iss_dst = 7; bus.ra1 = 7;
    repeat (3) tick();
    #1 chk("full7", 32'(bus.iss_full), 32'h1);
    chk("busy7", 32'(bus.busy1), 32'h1);
    tick();
    bus.iss_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.we = 1'b1; bus.wa = 7; bus.wd = $urandom;
      #1 chk("retire7", 32'(bus.busy1), (k == 2 && BYP) ? 32'h0 : 32'h1);
      tick();
    end
    idle();
    #1 chk("cleared7", 32'(bus.busy1), 32'h0);
    tick();
    bus.iss_en = 1'b1; bus.iss_dst = 9;
    tick();
    bus.we = 1'b1; bus.wa = 9; bus.wd = 32'h99; bus.ra1 = 9;
    tick();
    idle();
    #1 chk("simul9", 32'(bus.busy1), 32'h1);
    tick();
    bus.we = 1'b1; bus.wa = 9;
    tick();
    idle();
    #1 chk("clear9", 32'(bus.busy1), 32'h0);
    tick();
    bus.we = 1'b1; bus.wa = 3; bus.wd = 32'h1111BABE; bus.ra1 = 3;
    #1 chk("bypass3", bus.rd1, BYP ? 32'h1111BABE : 32'h0);
    tick();
    idle();
    #1 chk("after3", bus.rd1, 32'h1111BABE);
    tick();
    bus.we = 1'b1; bus.wa = 4; bus.wd = 32'h44; bus.ra1 = 4;
    tick();
    idle();
    #1 chk("under4_busy", 32'(bus.busy1), 32'h0);
    chk("under4_rd", bus.rd1, 32'h44);
    tick();
    bus.iss_en = 1'b1; bus.iss_dst = 4;
    tick();
    idle();
    #1 chk("issue4", 32'(bus.busy1), 32'h1);
    tick();
    for (int i = 0; i < 300; i++) begin
      rand_in();
      tick();
    end
    idle();
    #2 rst = 1'b0;
    m_reset();
    for (int a = 0; a < 32; a++) begin
      bus.ra1 = 5'(a); bus.ra2 = 5'(31 - a); bus.iss_dst = 5'(a);
      #1;
      chk("rst_rd1", bus.rd1, 32'h0);
      chk("rst_rd2", bus.rd2, 32'h0);
      chk("rst_busy", 32'({bus.busy1, bus.busy2, bus.iss_full}), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_in();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

MIPS general-purpose register file (32 × 32-bit, two read ports, one write port) with a per-register outstanding-write scoreboard. Slot 0 is hardwired $zero. It sits between decode, which issues destination registers and reads sources, and write-back, which retires results. It feeds operand data and hazard flags to the decode/stall logic.

## Interface
Parameters:
- DATA_W, 32, register width
- CNT_W, 2, width of each per-register outstanding-write counter (max 2^CNT_W−1 in flight)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ra1  in  5  read address, port 1
- rd1  out  DATA_W  read data, port 1, combinational
- ra2  in  5  read address, port 2
- rd2  out  DATA_W  read data, port 2, combinational
- we  in  1  write-back enable
- wa  in  5  write-back address
- wd  in  DATA_W  write-back data
- iss_en  in  1  decode issues an instruction writing iss_dst
- iss_dst  in  5  destination of issued instruction
- busy1  out  1  ra1 has an outstanding write
- busy2  out  1  ra2 has an outstanding write
- iss_full  out  1  counter of iss_dst is saturated; decode must hold iss_en low

## Operation
- Storage: regs[1..31] written on rising clk when we=1 and wa≠0; wa=0 writes discarded.
- Reads: rdN = 0 when raN=0, else regs[raN].
- Scoreboard: cnt[r] per register r=1..31, cnt[0] constant 0.
  - inc = iss_en && iss_dst≠0 && !iss_full; dec = we && wa≠0 && cnt[wa]≠0.
  - Same register inc and dec in one cycle: count unchanged.
  - we to a register with cnt=0: data written, count stays 0 (no underflow).
  - iss_en while iss_full: ignored, count unchanged.
- busyN = (cnt[raN]≠0), forced 0 for raN=0.
- iss_full = (cnt[iss_dst] == 2^CNT_W−1), 0 for iss_dst=0.
- Reset (rst=0, any time, async): all regs[] = 0, all cnt = 0; hence rd1=rd2=0, busy1=busy2=0, iss_full=0 while in reset and the first cycle after.

## Timing
- Write latency: wd visible on rdN the cycle after the we edge (without bypass).
- Scoreboard latency: busyN reflects an issue on the following cycle; a retire clears it (if count reaches 0) on the following cycle.
- All outputs are combinational from current state and inputs; no registered outputs.
- Reset deasserting mid-operation: first edge after release behaves as normal operation from all-zero state.

## Configuration
- REGFILE_BYPASS_EN defined: if we=1, wa≠0, wa==raN, then rdN=wd in the same cycle. busyN is forced 0 when cnt[raN]==1 and the same-cycle write retires it.
- Undefined: no forwarding. rdN shows the old value until the next cycle, and busyN stays asserted through the retiring cycle.

## Structure
- Package regfile_pkg: DATA_W default, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0.
- Sub-module sb_counter: one CNT_W saturating up/down counter with inc, dec, async active-low reset, and outputs nz and full. Instantiated for r=1..31.

## Test plan
- Reset: pulse rst low mid-run after writes -> rd1/rd2 read 0 for every address, and busy/iss_full read 0 immediately (asynchronously).
- Write/read: we=1, wa=5, wd=32'hDEADBEEF -> next cycle ra1=5 gives rd1=32'hDEADBEEF. Then we=1, wa=0, wd=32'h0000BABE -> rd2 at ra2=0 stays 0.
- Scoreboard: iss_en with iss_dst=7 for 3 cycles -> iss_full=1 at iss_dst=7. A 4th issue is ignored. Then 3 retires to wa=7 -> busy1 at ra1=7 goes 1,1,1,0.
- Simultaneous: cnt[9]=1, same cycle iss_dst=9 and wa=9 -> busy for 9 stays 1 and the count stays 1. A later single retire clears busy.
- Bypass (REGFILE_BYPASS_EN): we=1, wa=3, wd=32'h1111BABE, ra1=3 -> rd1=32'h1111BABE in the same cycle. Without the macro, rd1 shows the old value that cycle.
- Underflow: retire to wa=4 with cnt=0 -> data written, busy stays 0, and a subsequent issue to 4 sets busy=1.
